// File: rtl/t09_score_pkg.sv
// rtl/t09_score_pkg.sv - shared types and constants for the snake-game score display
package t09_score_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_OVER = 2'd1,
    ST_WIN  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a} codes for BCD digits 0..9
  localparam logic [6:0] SEG_CODES [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [31:0] bin_to_bcd(input int unsigned value);
    logic [31:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/t09_bcd_seg7.sv
// rtl/t09_bcd_seg7.sv - combinational BCD digit to seven-segment decoder with blanking
module t09_bcd_seg7
  import t09_score_pkg::*;
(
  input  bcd_digit_t  i_digit,
  input  logic        i_blank,
  output logic [6:0]  o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && (i_digit <= 4'd9)) begin
      o_seg = SEG_CODES[i_digit];
    end
  end

endmodule

// File: rtl/t09_score_display_n.sv
// rtl/t09_score_display_n.sv - BCD score/high-score counter, play/over/win FSM and
// multiplexed seven-segment scanner with leading-zero blanking and end-of-game blink
module t09_score_display_n
  import t09_score_pkg::*;
#(
  parameter int DIGITS      = 3,
  parameter int SCAN_CYCLES = 1000,
  parameter int BLINK_SCANS = 250,
  parameter int WIN_SCORE   = 78
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                clear_i,
  input  logic                inc_i,
  input  logic                over_i,
  input  logic                show_hi_i,
  output logic [4*DIGITS-1:0] score_o,
  output logic [4*DIGITS-1:0] hiscore_o,
  output logic                complete_o,
  output logic                won_o,
  output logic [DIGITS-1:0]   digit_sel_o,
  output logic [6:0]          seg_o
);

  localparam int W  = 4 * DIGITS;
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [31:0]  WIN_BCD32 = bin_to_bcd(WIN_SCORE);
  localparam logic [W-1:0] WIN_BCD   = WIN_BCD32[W-1:0];

  logic          r_inc_q, r_over_q;
  state_t        r_state, w_state_next;
  logic [W-1:0]  r_score, r_hiscore, w_score_next, w_score_inc;
  logic          w_inc_ev, w_over_ev, w_all9, w_carry, w_enter_end;
  logic [SW-1:0] r_slot;
  logic [IW-1:0] r_idx;
  logic [BW-1:0] r_rot;
  logic          r_phase, w_phase_on, w_slot_wrap, w_rot_done;
  logic [DIGITS-1:0] r_sel;
  logic [6:0]    r_seg, w_seg;
  logic [W-1:0]  w_src;
  bcd_digit_t    w_digit;
  logic          w_blank, w_zero_run;

  assign w_inc_ev  = inc_i & ~r_inc_q;
  assign w_over_ev = over_i & ~r_over_q;

  // Ripple-carry BCD increment that saturates at all nines
  always_comb begin
    w_score_inc = r_score;
    w_all9      = 1'b1;
    w_carry     = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_score[4*k +: 4] != 4'd9) w_all9 = 1'b0;
      if (w_carry) begin
        if (r_score[4*k +: 4] == 4'd9) begin
          w_score_inc[4*k +: 4] = 4'd0;
        end else begin
          w_score_inc[4*k +: 4] = r_score[4*k +: 4] + 4'd1;
          w_carry = 1'b0;
        end
      end
    end
    if (w_all9) w_score_inc = r_score;
  end

  always_comb begin
    w_state_next = r_state;
    w_score_next = r_score;
    if (clear_i) begin
      w_state_next = ST_PLAY;
      w_score_next = '0;
    end else if (r_state == ST_PLAY) begin
      if (w_over_ev) begin
        w_state_next = ST_OVER;
      end else if (w_inc_ev) begin
        w_score_next = w_score_inc;
        if (w_score_inc == WIN_BCD) w_state_next = ST_WIN;
      end
    end
  end

  assign w_enter_end = !clear_i && (r_state == ST_PLAY) && (w_state_next != ST_PLAY);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_inc_q   <= 1'b0;
      r_over_q  <= 1'b0;
      r_state   <= ST_PLAY;
      r_score   <= '0;
      r_hiscore <= '0;
    end else begin
      r_inc_q  <= inc_i;
      r_over_q <= over_i;
      r_state  <= w_state_next;
      r_score  <= w_score_next;
      if (w_enter_end && (w_score_next > r_hiscore)) r_hiscore <= w_score_next;
    end
  end

  // Digit mux and leading-zero blanking, scanned from the most significant digit down
  always_comb begin
    w_src      = show_hi_i ? r_hiscore : r_score;
    w_digit    = w_src[3:0];
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (w_src[4*k +: 4] == 4'd0);
      if (r_idx == IW'(k)) begin
        w_digit = w_src[4*k +: 4];
        w_blank = w_zero_run && (k != 0);
      end
    end
  end

  t09_bcd_seg7 u_seg7 (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  assign w_slot_wrap = (r_slot == SW'(SCAN_CYCLES - 1));
  assign w_rot_done  = w_slot_wrap && (r_idx == IW'(DIGITS - 1));
  assign w_phase_on  = (r_state == ST_PLAY) || r_phase;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_slot  <= '0;
      r_idx   <= '0;
      r_rot   <= '0;
      r_phase <= 1'b1;
      r_sel   <= DIGITS'(1);
      r_seg   <= 7'h3F;
    end else begin
      if (clear_i) begin
        r_slot  <= '0;
        r_idx   <= '0;
        r_rot   <= '0;
        r_phase <= 1'b1;
      end else begin
        r_slot <= w_slot_wrap ? '0 : r_slot + SW'(1);
        if (w_slot_wrap) r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
        // Holding the blink state reset during play makes every game end start "on"
        if (r_state == ST_PLAY) begin
          r_rot   <= '0;
          r_phase <= 1'b1;
        end else if (w_rot_done) begin
          if (r_rot == BW'(BLINK_SCANS - 1)) begin
            r_rot   <= '0;
            r_phase <= ~r_phase;
          end else begin
            r_rot <= r_rot + BW'(1);
          end
        end
      end
      r_sel <= DIGITS'(1) << r_idx;
      r_seg <= w_phase_on ? w_seg : SEG_BLANK;
    end
  end

  assign score_o     = r_score;
  assign hiscore_o   = r_hiscore;
  assign complete_o  = (r_state != ST_PLAY);
  assign won_o       = (r_state == ST_WIN);
  assign digit_sel_o = r_sel;
  assign seg_o       = r_seg;

endmodule

// File: tb/tb_t09_score_display_n.sv
// tb/tb_t09_score_display_n.sv - directed self-checking bench for t09_score_display_n
module tb_t09_score_display_n;

  logic        clk = 1'b0;
  logic        nRst;
  logic        clear_i, inc_i, over_i, show_hi_i;
  logic [11:0] score_o, hiscore_o;
  logic        complete_o, won_o;
  logic [2:0]  digit_sel_o;
  logic [6:0]  seg_o;

  int n_cmp = 0;
  int n_fail = 0;

  t09_score_display_n #(
    .DIGITS(3), .SCAN_CYCLES(4), .BLINK_SCANS(2), .WIN_SCORE(12)
  ) dut (
    .clk(clk), .nRst(nRst), .clear_i(clear_i), .inc_i(inc_i), .over_i(over_i),
    .show_hi_i(show_hi_i), .score_o(score_o), .hiscore_o(hiscore_o),
    .complete_o(complete_o), .won_o(won_o), .digit_sel_o(digit_sel_o), .seg_o(seg_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_inc();
    inc_i = 1'b1;
    @(negedge clk);
    inc_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  task automatic wait_sel(input string tag, input logic [2:0] want);
    bit hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (digit_sel_o === want) hit = 1'b1;
    end
    if (!hit) check({tag, "_timeout"}, {29'd0, digit_sel_o}, {29'd0, want});
  endtask

  initial begin
    bit found;
    nRst = 1'b0; clear_i = 1'b0; inc_i = 1'b0; over_i = 1'b0; show_hi_i = 1'b0;
    #12;
    check("rst_score", score_o, 0);
    check("rst_hiscore", hiscore_o, 0);
    check("rst_complete", complete_o, 0);
    check("rst_won", won_o, 0);
    check("rst_sel", digit_sel_o, 3'b001);
    check("rst_seg", seg_o, 7'h3F);
    @(negedge clk);
    nRst = 1'b1;

    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("idle_sel", digit_sel_o, 3'b001 << ((k - 1) / 4));
      check("idle_seg", seg_o, (k <= 4) ? 7'h3F : 7'h00);
    end

    for (int k = 0; k < 9; k++) pulse_inc();
    check("score_009", score_o, 12'h009);
    pulse_inc();
    check("score_010", score_o, 12'h010);
    wait_sel("w1", 3'b010);
    check("seg_d1_one", seg_o, 7'h06);
    wait_sel("w2", 3'b100);
    check("seg_d2_blank", seg_o, 7'h00);
    wait_sel("w3", 3'b001);
    check("seg_d0_zero", seg_o, 7'h3F);

    pulse_clear();
    check("clear_score", score_o, 0);
    for (int k = 0; k < 11; k++) pulse_inc();
    check("score_011", score_o, 12'h011);
    check("won_pre", won_o, 0);
    inc_i = 1'b1;
    @(negedge clk);
    check("win_won", won_o, 1);
    check("win_complete", complete_o, 1);
    check("win_hiscore", hiscore_o, 12'h012);
    check("win_score", score_o, 12'h012);
    inc_i = 1'b0;
    @(negedge clk);
    pulse_inc();
    check("win_hold_score", score_o, 12'h012);

    pulse_clear();
    check("clr2_complete", complete_o, 0);
    check("clr2_won", won_o, 0);
    check("clr2_hiscore", hiscore_o, 12'h012);
    for (int k = 0; k < 5; k++) pulse_inc();
    check("score_005", score_o, 12'h005);
    over_i = 1'b1;
    @(negedge clk);
    check("over_complete", complete_o, 1);
    check("over_won", won_o, 0);
    check("over_hiscore", hiscore_o, 12'h012);
    check("over_score", score_o, 12'h005);
    repeat (9) @(negedge clk);
    over_i = 1'b0;
    pulse_inc();
    check("over_inc_ignored", score_o, 12'h005);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (digit_sel_o === 3'b001 && seg_o === 7'h00) found = 1'b1;
    end
    check("blink_off_found", found, 1);
    for (int i = 1; i <= 5; i++) begin
      repeat (12) @(negedge clk);
      check("blink_sel", digit_sel_o, 3'b001);
      check("blink_seg", seg_o, (i == 2 || i == 3) ? 7'h6D : 7'h00);
    end

    pulse_clear();
    for (int k = 0; k < 3; k++) pulse_inc();
    inc_i = 1'b1; over_i = 1'b1;
    @(negedge clk);
    check("both_complete", complete_o, 1);
    check("both_won", won_o, 0);
    check("both_score", score_o, 12'h003);
    check("both_hiscore", hiscore_o, 12'h012);
    inc_i = 1'b0; over_i = 1'b0;
    @(negedge clk);
    clear_i = 1'b1; inc_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; inc_i = 1'b0;
    check("clrinc_score", score_o, 0);
    check("clrinc_complete", complete_o, 0);
    @(negedge clk);

    inc_i = 1'b1;
    repeat (50) @(negedge clk);
    check("held_inc", score_o, 12'h001);
    inc_i = 1'b0;
    @(negedge clk);

    show_hi_i = 1'b1;
    wait_sel("w4", 3'b010);
    check("hi_d1", seg_o, 7'h06);
    wait_sel("w5", 3'b001);
    check("hi_d0", seg_o, 7'h5B);
    show_hi_i = 1'b0;

    wait_sel("w6", 3'b100);
    #2 nRst = 1'b0;
    #1;
    check("arst_score", score_o, 0);
    check("arst_hiscore", hiscore_o, 0);
    check("arst_complete", complete_o, 0);
    check("arst_won", won_o, 0);
    check("arst_sel", digit_sel_o, 3'b001);
    check("arst_seg", seg_o, 7'h3F);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/t09_score_display_n.md
# t09_score_display_n

Parametrised score unit for the snake game: a DIGITS-wide packed-BCD score counter with high-score register, game-state FSM (play / over / win), and a time-multiplexed seven-segment scanner with leading-zero blanking and end-of-game blink. It is driven by the collision outputs (good/bad collision) and the new-game sync pulse, and drives the seven-segment pins. It generalises the fixed 3-digit score/toggle/decoder path to N digits, adds a high score, win detection and blinking.

## Interface
- DIGITS, 3: number of BCD digits, legal 1..8.
- SCAN_CYCLES, 1000: clock cycles each digit is selected; legal ≥ 2.
- BLINK_SCANS, 250: full scan rotations per blink half-period; legal ≥ 1.
- WIN_SCORE, 78: binary score value that ends the game as won; legal 1..10^DIGITS-1.

- clk  in  1  system clock; single clock domain.
- nRst  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous new-game pulse.
- inc_i  in  1  good-collision level; each rising edge adds 1.
- over_i  in  1  bad-collision level; a rising edge ends the game.
- show_hi_i  in  1  0 = display score, 1 = display high score.
- score_o  out  4*DIGITS  packed BCD score, digit 0 in [3:0].
- hiscore_o  out  4*DIGITS  packed BCD high score.
- complete_o  out  1  high in OVER or WIN.
- won_o  out  1  high in WIN.
- digit_sel_o  out  DIGITS  one-hot active-high digit enable.
- seg_o  out  7  active-high segments {g,f,e,d,c,b,a}.

## Operation
- Edge detect: registered copies of inc_i and over_i; event = current & ~previous. Previous copies reset to 0.
- FSM states PLAY, OVER, WIN; reset → PLAY.
- PLAY: inc event → score +1 in BCD with ripple carry. At all-9s it saturates. If the new score equals WIN_SCORE (BCD of it), go to WIN. over event → OVER.
- OVER/WIN: inc and over events are ignored.
- Any state: clear_i → PLAY, score = 0, blink phase = on. hiscore is retained.
- Priority in one cycle: clear_i > over event > inc event. On simultaneous over and inc, the inc is dropped.
- High score: on the transition into OVER or WIN, hiscore ← score if score > hiscore. Packed-BCD compares as unsigned.
- Display source: hiscore when show_hi_i = 1, else score.
- Scanner: a slot counter runs 0..SCAN_CYCLES-1. On wrap, the digit index advances modulo DIGITS. digit_sel_o = 1 << index.
- Leading-zero blanking: digit k is blank if it and all higher digits are 0, for k > 0. Digit 0 is never blanked.
- Blink: in OVER/WIN a rotation counter toggles the phase every BLINK_SCANS completed rotations. During the off phase seg_o = 0, but digit_sel_o keeps scanning. In PLAY the phase is forced on. Entering OVER/WIN starts with the on phase and the rotation counter at 0.
- Segment codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other value or blank = 00.

## Timing
- Reset values: score_o 0, hiscore_o 0, complete_o 0, won_o 0, digit_sel_o = 1, seg_o = 7'h3F, slot counter 0, index 0.
- score_o updates on the edge that first samples inc_i high; 1-cycle latency.
- complete_o/won_o assert on the same edge as the score update or over event that causes the transition. hiscore_o updates on that same edge.
- digit_sel_o and seg_o are registered together; they change on the same edge, one cycle after the slot wrap. They are never mismatched.
- A held inc_i or over_i counts once. Re-arming requires inc_i/over_i to be sampled low for at least one cycle.
- clear_i is effective on the sampling edge. Counters restart immediately.
- Reset asserted mid-operation returns to the reset values asynchronously, including hiscore.

## Structure
- Package t09_score_pkg holds:
  - the state enum (PLAY, OVER, WIN),
  - the 10-entry segment constant array,
  - the BLANK code,
  - a bcd_digit_t 4-bit typedef.
- One sub-module, t09_bcd_seg7: a combinational 4-bit digit plus blank → 7 segments, instanced once after the digit mux.
- The BCD counter and scanner stay inline.

## Test plan
All scenarios use DIGITS=3, SCAN_CYCLES=4, BLINK_SCANS=2, WIN_SCORE=12.
- Reset, then 12 cycles idle → score_o=000, digit_sel cycles 001→010→100 every 4 cycles, seg_o=3F only on digit 0 and 00 on digits 1 and 2.
- 9 inc pulses then 1 more → score_o 0x009 then 0x010; seg_o shows 06 on digit 1 and 3F on digit 0.
- 12 inc pulses → won_o=1 and complete_o=1 on the 12th update edge, hiscore_o=0x012; a 13th pulse leaves score at 0x012.
- clear_i, then 5 inc, then over_i held 10 cycles → complete_o=1, won_o=0, hiscore_o stays 0x012, score_o=0x005; seg_o toggles between on and 00 every 24 cycles.
- inc_i and over_i rising in the same cycle → state OVER and score unchanged. Then clear_i together with an inc edge → score_o=000 and state PLAY.
- inc_i held high for 50 cycles → score +1 only. Assert nRst mid-scan → all outputs return to reset values without a clock edge.
